// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serial loader that streams a bitstream into a ccff configuration chain
//
// Purpose: accepts BYTE_W-bit bitstream words, MSB first, and shifts exactly
// CHAIN_LEN bits into a configuration flip-flop chain. The chain clock is
// gated externally by shift_en. Any low-order bits of the final word that do
// not fit the chain are dropped.
//
// Ports:
//   prog_clk   - configuration clock; all state updates on its rising edge
//   prog_rst_n - asynchronous active-low reset
//   start      - single-cycle request to begin a load (ignored while busy)
//   abort      - single-cycle request to cancel a load in progress
//   s_data     - bitstream word, MSB shifted first
//   s_valid    - s_data is valid
//   s_ready    - loader accepts s_data this cycle
//   ccff_head  - serial bit into the chain head; 0 whenever shift_en is 0
//   shift_en   - chain clock enable; the chain shifts on exactly these cycles
//   busy       - load in progress
//   done       - last load completed with exactly CHAIN_LEN bits
//   err        - last load was aborted
module ccff_loader #(
  parameter int CHAIN_LEN = 29,
  parameter int BYTE_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // bit_cnt has to hold the value CHAIN_LEN itself without wrapping
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(BYTE_W - 1);

  logic [1:0]        state_q,   state_d;
  logic [BYTE_W-1:0] sreg_q,    sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wbit_q,    wbit_d;     // bits already shifted from the current word
  logic              err_q,     err_d;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    wbit_d    = wbit_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start wins over a simultaneous abort here because nothing is in flight
        if (start) begin
          err_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (s_valid) begin
          sreg_d  = s_data;
          wbit_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d    = sreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        wbit_d    = wbit_q + 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bit_cnt_q == LAST_CNT) begin
          // chain full: leave mid-word, the rest of the word is discarded
          state_d = ST_DONE;
        end else if (wbit_q == LAST_WB) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      wbit_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      wbit_q    <= wbit_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode straight from the state flop so reset clears them at once
  assign s_ready   = (state_q == ST_WAIT);
  assign shift_en  = (state_q == ST_SHIFT);
  assign ccff_head = shift_en & sreg_q[BYTE_W-1];
  assign busy      = s_ready | shift_en;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - self-checking bench for ccff_loader
module tb_ccff_loader;

  localparam int CL = 29;
  localparam int BW = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          prog_rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic          s_ready, ccff_head, shift_en, busy, done, err;

  logic          start8 = 1'b0, abort8 = 1'b0, s_valid8 = 1'b0;
  logic [7:0]    s_data8 = '0;
  logic          s_ready8, ccff_head8, shift_en8, busy8, done8, err8;

  ccff_loader #(.CHAIN_LEN(CL), .BYTE_W(BW)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .shift_en(shift_en), .busy(busy), .done(done), .err(err)
  );

  ccff_loader #(.CHAIN_LEN(8), .BYTE_W(8)) dut8 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start8), .abort(abort8),
    .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8), .ccff_head(ccff_head8),
    .shift_en(shift_en8), .busy(busy8), .done(done8), .err(err8)
  );

  int checks = 0;
  int errors = 0;
  int mon_err = 0;

  logic          cap[$];      // ccff_head captured on every shift_en cycle
  logic          exp_q[$];    // bits the chain should receive, in order
  logic [7:0]    wq[$];       // words to feed for the current load
  logic [CL-1:0] chain_m = '0;
  logic [CL-1:0] exp_chain;
  bit            hs_pend = 1'b0;
  int            word_shifts = 0;

  // Protocol monitor on the 29-bit instance, sampling mid low phase
  always @(negedge prog_clk) begin : mon
    int e;
    int ws;
    #2;
    e  = 0;
    ws = hs_pend ? 0 : word_shifts;
    if (hs_pend && !shift_en) e++;
    if (shift_en) begin
      cap.push_back(ccff_head);
      chain_m <= {chain_m[CL-2:0], ccff_head};
      ws++;
      if (ws > BW) e++;
    end else if (ccff_head !== 1'b0) begin
      e++;
    end
    word_shifts <= ws;
    hs_pend     <= s_valid && s_ready && prog_rst_n && !abort;
    mon_err     <= mon_err + e;
  end

  task automatic build_exp();
    exp_q.delete();
    foreach (wq[i])
      for (int b = BW - 1; b >= 0; b--)
        if (exp_q.size() < CL) exp_q.push_back(wq[i][b]);
    exp_chain = '0;
    foreach (exp_q[i]) exp_chain[CL-1-i] = exp_q[i];
  endtask

  task automatic rand_words();
    wq.delete();
    repeat (4) wq.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit hold_high, input int max_gap, input bit start_in_shift, output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < wq.size(); i++) begin
      n = 0;
      while (!s_ready && n < 100) begin
        @(negedge prog_clk);
        n++;
      end
      if (!s_ready) begin
        ok = 1'b0;
        s_valid = 1'b0;
        return;
      end
      if (!hold_high) repeat ($urandom_range(0, max_gap)) @(negedge prog_clk);
      s_data  = wq[i];
      s_valid = 1'b1;
      @(negedge prog_clk);
      if (!hold_high) s_valid = 1'b0;
      if (start_in_shift && i == 0) begin
        start = 1'b1;
        repeat (3) @(negedge prog_clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    ok = done;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({s_ready, ccff_head, shift_en, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_held outputs=%b required=000000", {s_ready, ccff_head, shift_en, busy, done, err});
    end
    prog_rst_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({s_ready, ccff_head, shift_en, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_released outputs=%b required=000000", {s_ready, ccff_head, shift_en, busy, done, err});
    end
    checks++;
    if ({s_ready8, ccff_head8, shift_en8, busy8, done8, err8} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut8 outputs=%b required=000000", {s_ready8, ccff_head8, shift_en8, busy8, done8, err8});
    end
  endtask

  // One full load from IDLE/DONE; hold_high keeps s_valid asserted throughout
  task automatic test_load(input string name, input bit hold_high, input int max_gap);
    bit ok1, ok2, mis;
    int e0;
    build_exp();
    cap.delete();
    e0 = mon_err;
    pulse_start();
    feed(hold_high, max_gap, 1'b0, ok1);
    wait_done(ok2);
    @(negedge prog_clk);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL %s_timeout feed_ok=%0d done_ok=%0d required 1 1", name, ok1, ok2);
    end
    mis = (cap.size() != exp_q.size());
    if (!mis) foreach (exp_q[i]) if (cap[i] !== exp_q[i]) mis = 1'b1;
    checks++;
    if (mis) begin
      errors++;
      $display("FAIL %s_bits got %0d shifted bits (or wrong values), required %0d matching", name, cap.size(), exp_q.size());
    end
    checks++;
    if (chain_m !== exp_chain) begin
      errors++;
      $display("FAIL %s_chain got %h required %h", name, chain_m, exp_chain);
    end
    checks++;
    if ({done, busy, err, shift_en} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_final done/busy/err/shift_en=%b required 1000", name, {done, busy, err, shift_en});
    end
    checks++;
    if (mon_err != e0) begin
      errors++;
      $display("FAIL %s_protocol violations=%0d required 0", name, mon_err - e0);
    end
  endtask

  task automatic test_directed();
    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h80};
    test_load("directed", 1'b1, 0);
  endtask

  task automatic test_gaps();
    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h80};
    test_load("gaps", 1'b0, 3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      rand_words();
      test_load($sformatf("random%0d", k), 1'($urandom_range(0, 1)), 4);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    cap.delete();
    pulse_start();
    s_data  = 8'($urandom);
    s_valid = 1'b1;
    while (cap.size() < 12 && n < 100) begin
      @(negedge prog_clk);
      #3;
      n++;
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    checks++;
    if ({busy, err, done, shift_en, s_ready} !== 5'b01000) begin
      errors++;
      $display("FAIL abort_state busy/err/done/shift_en/s_ready=%b required 01000", {busy, err, done, shift_en, s_ready});
    end
    repeat (2) @(negedge prog_clk);
    #3;
    checks++;
    if (cap.size() != 12) begin
      errors++;
      $display("FAIL abort_shift_count got %0d required 12", cap.size());
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    @(negedge prog_clk);
    checks++;
    if ({busy, err} !== 2'b01) begin
      errors++;
      $display("FAIL abort_in_idle busy/err=%b required 01", {busy, err});
    end
    pulse_start();
    checks++;
    if ({busy, s_ready, err} !== 3'b110) begin
      errors++;
      $display("FAIL abort_restart busy/s_ready/err=%b required 110", {busy, s_ready, err});
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    checks++;
    if ({busy, s_ready, err} !== 3'b001) begin
      errors++;
      $display("FAIL abort_in_wait busy/s_ready/err=%b required 001", {busy, s_ready, err});
    end
  endtask

  task automatic test_start_abort_idle();
    bit ok1, ok2, mis;
    rand_words();
    build_exp();
    cap.delete();
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, s_ready, err} !== 3'b110) begin
      errors++;
      $display("FAIL start_abort_idle busy/s_ready/err=%b required 110", {busy, s_ready, err});
    end
    feed(1'b0, 2, 1'b1, ok1);
    wait_done(ok2);
    mis = !(ok1 && ok2) || (cap.size() != exp_q.size());
    if (!mis) foreach (exp_q[i]) if (cap[i] !== exp_q[i]) mis = 1'b1;
    checks++;
    if (mis) begin
      errors++;
      $display("FAIL start_held_in_shift got %0d bits done=%0d, required %0d matching bits done=1", cap.size(), done, CL);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cap.delete();
    pulse_start();
    s_data  = 8'($urandom);
    s_valid = 1'b1;
    while (cap.size() < 5 && n < 100) begin
      @(negedge prog_clk);
      #3;
      n++;
    end
    prog_rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, ccff_head, shift_en, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_async outputs=%b required=000000", {s_ready, ccff_head, shift_en, busy, done, err});
    end
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    s_valid    = 1'b0;
    @(negedge prog_clk);
    #3;
    checks++;
    if (cap.size() != 5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse shifts=%0d busy=%0d required 5 0", cap.size(), busy);
    end
    @(negedge prog_clk);
    rand_words();
    test_load("after_reset", 1'b0, 2);
  endtask

  task automatic test_chain8();
    int n = 0, shifts = 0, last_shift = -1, first_done = -1;
    bit ready_seen = 1'b0, head_bad = 1'b0;
    logic [7:0] bits = '0;
    start8 = 1'b1;
    @(negedge prog_clk);
    start8 = 1'b0;
    while (!s_ready8 && n < 20) begin
      @(negedge prog_clk);
      n++;
    end
    s_data8  = 8'h5A;
    s_valid8 = 1'b1;
    @(negedge prog_clk);
    s_valid8 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (shift_en8) begin
        bits = {bits[6:0], ccff_head8};
        shifts++;
        last_shift = c;
      end else if (ccff_head8 !== 1'b0) begin
        head_bad = 1'b1;
      end
      if (s_ready8) ready_seen = 1'b1;
      if (done8 && first_done < 0) first_done = c;
      @(negedge prog_clk);
    end
    checks++;
    if (shifts != 8 || bits !== 8'h5A || head_bad) begin
      errors++;
      $display("FAIL chain8_bits shifts=%0d bits=%h head_bad=%0d required 8 5a 0", shifts, bits, head_bad);
    end
    checks++;
    if (ready_seen || first_done != last_shift + 1) begin
      errors++;
      $display("FAIL chain8_direct_done ready_seen=%0d done_at=%0d required 0 %0d", ready_seen, first_done, last_shift + 1);
    end
    start8 = 1'b1;
    @(negedge prog_clk);
    start8 = 1'b0;
    checks++;
    if ({busy8, s_ready8, done8} !== 3'b110) begin
      errors++;
      $display("FAIL chain8_restart busy/s_ready/done=%b required 110", {busy8, s_ready8, done8});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_random();
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_chain8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 29, number of configuration flops in the target ccff chain; legal range 1..65535.
REQ-002 Parameter BYTE_W, default 8, width of the bitstream input word.
REQ-003 prog_clk  input  1  configuration clock; all state updates on its rising edge.
REQ-004 prog_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 abort  input  1  single-cycle request to cancel a load in progress.
REQ-007 s_data  input  BYTE_W  bitstream word; MSB is shifted first.
REQ-008 s_valid  input  1  s_data is valid.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 ccff_head  output  1  serial bit driven into the chain head.
REQ-011 shift_en  output  1  clock-enable to the external gate of the chain prog_clk; the chain shifts exactly on cycles where shift_en=1.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed with exactly CHAIN_LEN bits shifted.
REQ-014 err  output  1  last load was aborted.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, SHIFT, DONE.
REQ-016 IDLE/DONE: start=1 SHALL clear done and err, clear bit_cnt to 0, and go to WAIT next cycle.
REQ-017 WAIT: s_ready=1; s_valid=1 SHALL load s_data into the shift register and go to SHIFT; s_valid=0 SHALL hold in WAIT with shift_en=0.
REQ-018 SHIFT: shift_en=1, ccff_head = shift register MSB; each cycle the shift register SHALL shift left by one and bit_cnt SHALL increment by one.
REQ-019 SHIFT exit: after BYTE_W bits of the current word, go to WAIT if bit_cnt < CHAIN_LEN; when bit_cnt reaches CHAIN_LEN, go to DONE immediately, even mid-word.
REQ-020 Partial final word: when CHAIN_LEN is not a multiple of BYTE_W, the unused low-order bits of the last word SHALL be discarded and never driven with shift_en=1.
REQ-021 Total cycles with shift_en=1 per completed load SHALL equal CHAIN_LEN exactly.
REQ-022 Latency: first shift_en=1 SHALL occur the cycle after the s_valid&s_ready handshake; at least one cycle with shift_en=0 SHALL separate consecutive words.
REQ-023 ccff_head SHALL be 0 whenever shift_en=0.
REQ-024 busy=1 in WAIT and SHIFT only; s_ready=1 in WAIT only.
REQ-025 DONE: done=1, shift_en=0, hold until start or reset.
REQ-026 abort=1 in WAIT or SHIFT SHALL go to IDLE next cycle, set err=1, done=0, with shift_en=0 from that next cycle; abort in IDLE/DONE SHALL be ignored.
REQ-027 abort and start asserted together SHALL act as abort if busy, as start otherwise.
REQ-028 start while busy SHALL be ignored.
REQ-029 bit_cnt width SHALL be ceil(log2(CHAIN_LEN+1)); it SHALL never wrap.

Reset
REQ-030 prog_rst_n=0 SHALL immediately force IDLE, shift register=0, bit_cnt=0, s_ready=0, ccff_head=0, shift_en=0, busy=0, done=0, err=0.
REQ-031 Reset mid-load SHALL leave no shift_en pulse after assertion; the chain contents are then undefined and a new load is required.

Verification
REQ-032 CHAIN_LEN=29, words 0xA5,0x3C,0xFF,0x80 with s_valid always high -> 29 shift_en cycles, ccff_head sequence 10100101 00111100 11111111 10000, low 3 bits of 0x80 discarded, done=1 after the last shift; a 29-flop model matches.
REQ-033 s_valid toggled 1-0-0-1 between words -> shift_en=0 during the gaps, bit sequence identical to REQ-032, done=1.
REQ-034 abort asserted after 12 shifted bits -> next cycle IDLE, err=1, done=0, busy=0, shift_en=0; a subsequent start clears err.
REQ-035 prog_rst_n pulsed low in SHIFT -> all outputs 0 asynchronously, state IDLE; start after release performs a full 29-bit load.
REQ-036 CHAIN_LEN=8 with one word 0x5A -> exactly 8 shifts, DONE entered directly from SHIFT, s_ready never asserted again; start in DONE restarts the load.
REQ-037 start and abort together in IDLE -> load starts; start held during SHIFT -> ignored, bit count unaffected.
